// File: rtl/cache_tag_ctrl.sv
// Tag lookup and MSI state-update controller for a 2-way L1 cache.
// Handles one request at a time. It reads both tag RAMs, classifies the access
// and returns a response. On UPGRADE or MISS it waits for a fill and then
// writes {state, tag} into the target way.
module cache_tag_ctrl #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned OFF_W  = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [DWIDTH-2+AWIDTH+OFF_W-1:0] req_addr,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [1:0]                       resp_code,
  output logic                             resp_way,
  output logic [DWIDTH-3:0]                resp_victim_tag,
  output logic                             resp_victim_dirty,
  input  logic                             fill_valid,
  input  logic [1:0]                       fill_state,
  output logic                             fill_ready,
  output logic [AWIDTH-1:0]                tram_addr,
  output logic [DWIDTH-1:0]                tram_din,
  output logic                             t0_we,
  output logic                             t1_we,
  input  logic [DWIDTH-1:0]                t0_dout,
  input  logic [DWIDTH-1:0]                t1_dout
);

  localparam int unsigned TAG_W  = DWIDTH - 2;
  localparam int unsigned ADDR_W = TAG_W + AWIDTH + OFF_W;
  localparam int unsigned SETS   = 1 << AWIDTH;

  localparam logic [1:0] HIT_RD  = 2'b00;
  localparam logic [1:0] HIT_WR  = 2'b01;
  localparam logic [1:0] UPGRADE = 2'b10;
  localparam logic [1:0] MISS    = 2'b11;
  localparam logic [1:0] ST_S    = 2'b01;
  localparam logic [1:0] ST_M    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_COMPARE, S_RESP, S_WAIT_FILL, S_WRITE
  } state_t;

  typedef struct packed {
    logic [1:0]       code;
    logic             way;
    logic [TAG_W-1:0] vtag;
    logic             vdirty;
  } resp_t;

  state_t           state, state_next;
  logic             wr_q;
  logic [TAG_W-1:0] tag_q;
  logic [AWIDTH-1:0] idx_q;
  logic [SETS-1:0]  lru_q;
  resp_t            resp_q, resp_d;
  logic             accept, lru_we, lru_bit;

  logic [1:0]       st0, st1;
  logic [TAG_W-1:0] tg0, tg1;
  logic             v0, v1, h0, h1, victim;
  logic [1:0]       hit_st;

  // The block offset is not used here.
  logic unused_off;
  assign unused_off = ^req_addr[OFF_W-1:0];

  assign st0 = t0_dout[DWIDTH-1 -: 2];
  assign st1 = t1_dout[DWIDTH-1 -: 2];
  assign tg0 = t0_dout[TAG_W-1:0];
  assign tg1 = t1_dout[TAG_W-1:0];

  // Classify the access from the tag RAM read data. Way 0 wins when both ways hit.
  // A miss evicts the first invalid way, otherwise the way the LRU bit names.
  always_comb begin
    resp_d = '0;
    hit_st = 2'b00;
    victim = 1'b0;
    v0 = (st0 == ST_S) || (st0 == ST_M);
    v1 = (st1 == ST_S) || (st1 == ST_M);
    h0 = v0 && (tg0 == tag_q);
    h1 = v1 && (tg1 == tag_q);
    if (h0 || h1) begin
      resp_d.way = ~h0;
      hit_st     = h0 ? st0 : st1;
      if (!wr_q)                resp_d.code = HIT_RD;
      else if (hit_st == ST_M)  resp_d.code = HIT_WR;
      else                      resp_d.code = UPGRADE;
    end else begin
      if (!v0)      victim = 1'b0;
      else if (!v1) victim = 1'b1;
      else          victim = lru_q[idx_q];
      resp_d.code   = MISS;
      resp_d.way    = victim;
      resp_d.vtag   = victim ? tg1 : tg0;
      resp_d.vdirty = victim ? (st1 == ST_M) : (st0 == ST_M);
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic, request capture strobe and LRU update strobe.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    lru_we     = 1'b0;
    lru_bit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ:    state_next = S_COMPARE;
      S_COMPARE: state_next = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          if ((resp_q.code == HIT_RD) || (resp_q.code == HIT_WR)) begin
            lru_we     = 1'b1;
            lru_bit    = ~resp_q.way;
            state_next = S_IDLE;
          end else begin
            state_next = S_WAIT_FILL;
          end
        end
      end
      S_WAIT_FILL: if (fill_valid) state_next = S_WRITE;
      S_WRITE: begin
        lru_we     = 1'b1;
        lru_bit    = ~resp_q.way;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request fields, response fields and per-set LRU bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q   <= 1'b0;
      tag_q  <= '0;
      idx_q  <= '0;
      resp_q <= '0;
      lru_q  <= '0;
    end else begin
      if (accept) begin
        wr_q  <= req_write;
        tag_q <= req_addr[ADDR_W-1 -: TAG_W];
        idx_q <= req_addr[OFF_W +: AWIDTH];
      end
      if (state == S_COMPARE) resp_q <= resp_d;
      if (lru_we) lru_q[idx_q] <= lru_bit;
    end
  end

  // Registered handshake and RAM-write outputs, decoded from the next state.
  // The fill state is captured into tram_din at the fill handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      fill_ready <= 1'b0;
      t0_we      <= 1'b0;
      t1_we      <= 1'b0;
      tram_din   <= '0;
    end else begin
      req_ready  <= (state_next == S_IDLE);
      resp_valid <= (state_next == S_RESP);
      fill_ready <= (state_next == S_WAIT_FILL);
      t0_we      <= (state_next == S_WRITE) && !resp_q.way;
      t1_we      <= (state_next == S_WRITE) &&  resp_q.way;
      tram_din   <= (state_next == S_WRITE) ? {fill_state, tag_q} : '0;
    end
  end

  assign tram_addr         = idx_q;
  assign resp_code         = resp_q.code;
  assign resp_way          = resp_q.way;
  assign resp_victim_tag   = resp_q.vtag;
  assign resp_victim_dirty = resp_q.vdirty;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboard bench for cache_tag_ctrl. A reference model of tags, MSI states
// and LRU bits predicts each response and each tag RAM write. A negedge
// monitor compares them against the DUT.
module tb_cache_tag_ctrl;
  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned OW  = 2;
  localparam int unsigned TW  = DW - 2;
  localparam int unsigned ADW = TW + AW + OW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0, fill_valid = 1'b0;
  logic [ADW-1:0] req_addr = '0;
  logic [1:0] fill_state = '0;
  logic req_ready, resp_valid, resp_way, resp_victim_dirty, fill_ready, t0_we, t1_we;
  logic [1:0] resp_code;
  logic [TW-1:0] resp_victim_tag;
  logic [AW-1:0] tram_addr;
  logic [DW-1:0] tram_din, t0_dout, t1_dout;

  cache_tag_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .OFF_W(OW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_code(resp_code), .resp_way(resp_way),
    .resp_victim_tag(resp_victim_tag), .resp_victim_dirty(resp_victim_dirty),
    .fill_valid(fill_valid), .fill_state(fill_state), .fill_ready(fill_ready),
    .tram_addr(tram_addr), .tram_din(tram_din), .t0_we(t0_we), .t1_we(t1_we),
    .t0_dout(t0_dout), .t1_dout(t1_dout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Tag RAMs: synchronous read, plus a backdoor port for preloading.
  logic [DW-1:0] mem0 [8];
  logic [DW-1:0] mem1 [8];
  logic bd_we = 1'b0, bd_way = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_din = '0;
  always @(posedge clock) begin
    t0_dout <= mem0[tram_addr];
    t1_dout <= mem1[tram_addr];
    if (t0_we) mem0[tram_addr] <= tram_din;
    if (t1_we) mem1[tram_addr] <= tram_din;
    if (bd_we) begin
      if (bd_way) mem1[bd_addr] <= bd_din;
      else        mem0[bd_addr] <= bd_din;
    end
  end

  // Reference model of the cache contents.
  logic [1:0]    r_st  [2][8];
  logic [TW-1:0] r_tag [2][8];
  logic          r_lru [8];

  typedef struct {
    logic [1:0]    code;
    logic          way;
    logic [TW-1:0] vtag;
    logic          vdirty;
    int            acc;
  } exp_t;
  typedef struct {
    logic          way;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } wr_t;
  exp_t eq[$];
  wr_t  wq[$];

  int checks = 0, errors = 0;
  bit fill_expect = 1'b0, done = 1'b0, fin = 1'b0;

  function automatic bit is_valid(logic [1:0] s);
    return (s == 2'b01) || (s == 2'b10);
  endfunction

  // Expected response from the model: lowest-numbered hitting way; on a miss,
  // the first invalid way, otherwise the LRU way.
  function automatic exp_t predict(logic wr, logic [TW-1:0] tag, logic [AW-1:0] idx);
    exp_t e;
    int hw;
    e = '{code: 2'b00, way: 1'b0, vtag: '0, vdirty: 1'b0, acc: 0};
    hw = -1;
    for (int w = 1; w >= 0; w--)
      if (is_valid(r_st[w][idx]) && r_tag[w][idx] == tag) hw = w;
    if (hw >= 0) begin
      e.way = 1'(hw);
      if (!wr)                          e.code = 2'b00;
      else if (r_st[hw][idx] == 2'b10)  e.code = 2'b01;
      else                              e.code = 2'b10;
    end else begin
      e.code = 2'b11;
      if (!is_valid(r_st[0][idx]))      e.way = 1'b0;
      else if (!is_valid(r_st[1][idx])) e.way = 1'b1;
      else                              e.way = r_lru[idx];
      e.vtag   = r_tag[e.way][idx];
      e.vdirty = (r_st[e.way][idx] == 2'b10);
    end
    return e;
  endfunction

  // Monitor: reset values, write pulses, response latency, stability and contents.
  logic pv = 1'b0, pr = 1'b0, pway = 1'b0, pvd = 1'b0;
  logic [1:0] pcode = '0;
  logic [TW-1:0] pvt = '0;
  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || fill_ready !== 1'b0 || t0_we !== 1'b0 ||
          t1_we !== 1'b0 || tram_addr !== '0 || tram_din !== '0 || resp_code !== 2'b00 ||
          resp_way !== 1'b0 || resp_victim_tag !== '0 || resp_victim_dirty !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs got rr=%b rv=%b fr=%b we=%b%b addr=%0h din=%0h code=%0h need rr=1 rest=0",
                 req_ready, resp_valid, fill_ready, t1_we, t0_we, tram_addr, tram_din, resp_code);
      end
      pv = 1'b0;
    end else begin
      if (t0_we || t1_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_we got we=%b%b addr=%0h din=%0h need no write", t1_we, t0_we, tram_addr, tram_din);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (t0_we !== !w.way || t1_we !== w.way || tram_addr !== w.addr || tram_din !== w.din) begin
            errors++;
            $display("FAIL tram_write got we=%b%b addr=%0h din=%0h need way=%0d addr=%0h din=%0h",
                     t1_we, t0_we, tram_addr, tram_din, w.way, w.addr, w.din);
          end
        end
      end
      if (fill_expect) begin
        checks++;
        if (fill_ready !== 1'b1) begin
          errors++;
          $display("FAIL fill_ready got=%b need=1", fill_ready);
        end
      end
      if (resp_valid) begin
        checks++;
        if (req_ready !== 1'b0 || fill_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_during_resp got rr=%b fr=%b need 0 0", req_ready, fill_ready);
        end
        if (!pv) begin
          checks++;
          if (eq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp got code=%0h need no response", resp_code);
          end else if (cyc - eq[0].acc != 3) begin
            errors++;
            $display("FAIL resp_latency got=%0d need=3", cyc - eq[0].acc);
          end
        end else if (!pr) begin
          checks++;
          if ({resp_code, resp_way, resp_victim_tag, resp_victim_dirty} !== {pcode, pway, pvt, pvd}) begin
            errors++;
            $display("FAIL resp_stable got=%0h need=%0h",
                     {resp_code, resp_way, resp_victim_tag, resp_victim_dirty}, {pcode, pway, pvt, pvd});
          end
        end
        if (resp_ready && eq.size() != 0) begin
          exp_t e;
          e = eq.pop_front();
          checks++;
          if (resp_code !== e.code || resp_way !== e.way) begin
            errors++;
            $display("FAIL resp_code_way got code=%0h way=%0d need code=%0h way=%0d", resp_code, resp_way, e.code, e.way);
          end
          if (e.code == 2'b11) begin
            checks++;
            if (resp_victim_tag !== e.vtag || resp_victim_dirty !== e.vdirty) begin
              errors++;
              $display("FAIL victim got tag=%0h dirty=%b need tag=%0h dirty=%b",
                       resp_victim_tag, resp_victim_dirty, e.vtag, e.vdirty);
            end
          end
        end
      end
      pv = resp_valid; pr = resp_ready; pcode = resp_code; pway = resp_way;
      pvt = resp_victim_tag; pvd = resp_victim_dirty;
      if (done && !fin) begin
        fin = 1'b1;
        checks++;
        if (eq.size() != 0 || wq.size() != 0) begin
          errors++;
          $display("FAIL leftover got resp=%0d writes=%0d need 0 0", eq.size(), wq.size());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic stall(input string what);
    $display("FAIL timeout_%s got no progress need progress within 30 cycles", what);
    $fatal(1, "bench stalled");
  endtask

  task automatic preload(input logic way, input logic [AW-1:0] idx, input logic [1:0] st, input logic [TW-1:0] tag);
    bd_we = 1'b1; bd_way = way; bd_addr = idx; bd_din = {st, tag};
    tick();
    bd_we = 1'b0;
    r_st[way][idx] = st; r_tag[way][idx] = tag;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) r_lru[i] = 1'b0;
    tick();
  endtask

  // One request. mode 0: full fill. mode 1: stop in WAIT_FILL. mode 2: accept the fill, then stop in WRITE.
  task automatic run_req(input logic wr, input logic [TW-1:0] tag, input logic [AW-1:0] idx,
                         input int hold, input logic [1:0] fst, input bit junk, input int mode);
    exp_t e;
    int n;
    n = 0;
    while (!req_ready) begin
      if (n > 30) stall("req_ready");
      tick(); n++;
    end
    e = predict(wr, tag, idx);
    e.acc = cyc;
    eq.push_back(e);
    req_valid = 1'b1; req_write = wr; req_addr = {tag, idx, 2'($urandom)};
    tick();
    if (junk) begin req_write = ~wr; req_addr = ADW'($urandom); end
    else req_valid = 1'b0;
    n = 0;
    while (!resp_valid) begin
      if (n > 30) stall("resp_valid");
      tick(); n++;
    end
    for (int h = 0; h < hold; h++) begin
      if (junk) begin fill_valid = 1'($urandom); fill_state = 2'($urandom); end
      tick();
    end
    fill_valid = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    if (e.code < 2'b10) begin
      r_lru[idx] = ~e.way;
    end else if (mode != 1) begin
      fill_expect = 1'b1; fill_valid = 1'b1; fill_state = fst;
      if (mode == 0) begin
        wr_t w;
        w.way = e.way; w.addr = idx; w.din = {fst, tag};
        wq.push_back(w);
        r_st[e.way][idx] = fst; r_tag[e.way][idx] = tag; r_lru[idx] = ~e.way;
      end
      tick();
      fill_valid = 1'b0; fill_expect = 1'b0;
      if (mode == 0) tick();
    end
  endtask

  function automatic logic [TW-1:0] pick_tag(int k);
    case (k)
      0: return 14'h00A5;
      1: return 14'h0111;
      2: return 14'h3FFF;
      default: return 14'h2222;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) r_lru[i] = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) preload(1'(w), 3'(i), 2'b00, '0);
    reset = 1'b0;
    tick();

    // Load hit on way 0.
    preload(1'b0, 3'd3, 2'b01, 14'h00A5);
    run_req(1'b0, 14'h00A5, 3'd3, 0, 2'b00, 1'b0, 0);
    // Store to S: upgrade, then store hit on M.
    preload(1'b1, 3'd5, 2'b01, 14'h0111);
    run_req(1'b1, 14'h0111, 3'd5, 0, 2'b10, 1'b0, 0);
    run_req(1'b1, 14'h0111, 3'd5, 1, 2'b00, 1'b0, 0);
    // Dirty victim chosen by LRU, then the other way after the fill.
    preload(1'b0, 3'd2, 2'b10, 14'h0022);
    preload(1'b1, 3'd2, 2'b01, 14'h0044);
    run_req(1'b0, 14'h0033, 3'd2, 0, 2'b01, 1'b0, 0);
    run_req(1'b0, 14'h0055, 3'd2, 0, 2'b01, 1'b0, 0);
    // Invalid way 0 is the victim even though the LRU bit points at way 1.
    preload(1'b0, 3'd7, 2'b01, 14'h0070);
    run_req(1'b0, 14'h0070, 3'd7, 0, 2'b00, 1'b0, 0);
    preload(1'b0, 3'd7, 2'b11, 14'h0070);
    preload(1'b1, 3'd7, 2'b01, 14'h0071);
    run_req(1'b0, 14'h0072, 3'd7, 0, 2'b11, 1'b0, 0);
    run_req(1'b0, 14'h0073, 3'd7, 0, 2'b01, 1'b0, 0);
    // Response held for 5 cycles while junk requests and fills are driven.
    run_req(1'b0, 14'h00A5, 3'd3, 5, 2'b00, 1'b1, 0);
    // Reset in WAIT_FILL, then in WRITE; each request then misses again.
    run_req(1'b0, 14'h0123, 3'd6, 0, 2'b01, 1'b0, 1);
    do_reset();
    run_req(1'b0, 14'h0123, 3'd6, 0, 2'b01, 1'b0, 0);
    run_req(1'b1, 14'h0200, 3'd4, 0, 2'b10, 1'b0, 2);
    do_reset();
    run_req(1'b1, 14'h0200, 3'd4, 0, 2'b10, 1'b0, 0);

    // Random traffic over a small tag pool.
    for (int i = 0; i < 150; i++)
      run_req(1'($urandom), pick_tag($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 2), 2'($urandom), 1'($urandom), 0);

    tick(); tick();
    done = 1'b1;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
